uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmit framer and serialiser. It accepts a data word over a valid/ready handshake and emits start, data (LSB first), optional parity and 1 or 2 stop bits on tx_out. Parity mode and stop-bit count are run-time selectable per frame, and data width is a parameter. It sits between the UART register/FIFO front end and the pad, and is timed by an external baud-tick generator.

Parameters:
DWIDTH, 8, data bits per frame; legal range 5..9.
OVERSAMPLE, 16, baud_tick pulses per serial bit period; must be ≥ 1.

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
baud_tick  input  1  one-cycle enable pulse from the baud generator
tx_valid  input  1  data_in and config are valid
tx_ready  output  1  block can accept a frame this cycle
data_in  input  DWIDTH  word to transmit
par_type  input  2  00 none, 01 odd, 10 even, 11 none
stop2  input  1  0 = one stop bit, 1 = two stop bits
tx_out  output  1  serial line; idles high
tx_busy  output  1  a frame is in progress
tx_done  output  1  one-cycle pulse when the last stop bit completes

Behaviour:
- Reset (async, rst_n=0): state IDLE, tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, counters=0, shift register=0. Assertion mid-frame aborts the frame immediately. No partial bits are sent after release.
- Handshake: a frame is accepted on the rising edge where tx_valid && tx_ready. tx_ready is 1 only in IDLE. data_in, par_type and stop2 are latched at acceptance; later changes are ignored until the next frame.
- Parity is computed at acceptance from the latched word. Odd: bit = ~^data. Even: bit = ^data. Modes 00/11 emit no parity bit, which shortens the frame.
- FSM states and transitions:
  - IDLE: tx_out=1. On accept, go to START. tx_busy rises in the cycle after the accept edge; tx_out=0 is registered at that same edge.
  - START: holds tx_out=0 for OVERSAMPLE baud_ticks, then goes to DATA.
  - DATA: sends DWIDTH bits, LSB first, each held for OVERSAMPLE ticks. After the last bit, goes to PARITY if enabled, otherwise STOP.
  - PARITY: holds the parity bit for one bit period, then goes to STOP.
  - STOP: tx_out=1 for one bit period, or two if stop2 was latched as 1. On the final tick, tx_done=1 for one cycle and the FSM returns to IDLE, with tx_ready=1 in the same cycle.
- Bit timing:
  - A tick counter of width $clog2(OVERSAMPLE) counts baud_ticks and wraps at OVERSAMPLE-1. The bit boundary is the tick on which the counter equals OVERSAMPLE-1.
  - A bit counter of width $clog2(DWIDTH+1) counts data bits.
  - Counters advance only on baud_tick; clk cycles without a tick hold state.
- Back-to-back frames: tx_valid held high during the tx_done cycle is accepted in that cycle. The next start bit follows with no idle gap beyond the stop bit(s).
- tx_out is driven directly from a flop; it is never combinational.
- Frame length in bit periods = 1 + DWIDTH + (parity ? 1 : 0) + (stop2 ? 2 : 1).

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined:
  - Adds input port send_break (1 bit).
  - In IDLE, send_break=1 takes priority over tx_valid. The FSM enters BREAK and drives tx_out=0 for as long as send_break is held.
  - On deassertion it holds tx_out=1 for one bit period, then returns to IDLE.
  - tx_ready=0 and tx_busy=1 throughout; tx_done is not pulsed.
- Undefined: no port, no BREAK state; the FSM is exactly as above.

Decomposition:
- Package uart_pkg holds:
  - par_type_e enum: PAR_NONE=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10, PAR_NONE2=2'b11.
  - tx_state_e enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - The function calc_parity(data, par_type).
- One sub-module, uart_bit_timer: the tick counter that produces a bit_end strobe, with a restart input.
- The FSM and shift register stay in uart_tx_frame.

Test Plan:
All scenarios use DWIDTH=8, OVERSAMPLE=16 and baud_tick=1 every cycle.
- Data 0x55, even parity, stop2=0 → tx_out sequence 0,1,0,1,0,1,0,1,0,0(par),1, each bit held 16 cycles; tx_done pulses 176 cycles after the start bit begins.
- Data 0xA7, odd parity → parity bit 0 (five ones), 176-cycle frame. Data 0xA6, odd parity → parity bit 1.
- par_type=00, then 11, with data 0xFF and stop2=1 → no parity bit; frame is 11 bit periods (176 cycles); stop held high for 32 cycles.
- Two frames with tx_valid held continuously → second accepted in the tx_done cycle; second start bit begins exactly 16 cycles after the first frame's last stop period began, with no extra idle high.
- baud_tick once every 4 cycles → each bit lasts 64 clk cycles; state is unchanged on non-tick cycles.
- rst_n pulsed low mid-DATA → tx_out=1 and tx_ready=1 immediately (async). After release the line stays idle until a new tx_valid arrives.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and parity helper for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_EVEN  = 2'b10,
    PAR_NONE2 = 2'b11
  } par_type_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } tx_state_e;

  localparam int unsigned MAX_DWIDTH = 9;

  // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [MAX_DWIDTH-1:0] data,
                                       input par_type_e par_type);
    case (par_type)
      PAR_ODD:  calc_parity = ~^data;
      PAR_EVEN: calc_parity = ^data;
      default:  calc_parity = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts baud ticks and strobes bit_end on the last tick of each serial bit period.
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic baud_tick,
  input  logic restart,
  output logic bit_end
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

  logic [TW-1:0] tick_cnt;

  assign bit_end = baud_tick && !restart && (tick_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (restart) begin
      tick_cnt <= '0;
    end else if (baud_tick) begin
      tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, 1/2 stop bits.
// Define UART_TX_BREAK_EN to add the send_break input and BREAK state.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DWIDTH     = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              baud_tick,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DWIDTH-1:0] data_in,
  input  logic [1:0]        par_type,
  input  logic              stop2,
`ifdef UART_TX_BREAK_EN
  input  logic              send_break,
`endif
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BW = $clog2(DWIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DWIDTH - 1);

  tx_state_e         state;
  logic [DWIDTH-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic              par_bit_q;
  logic              par_en_q;
  logic              stop2_q;
  logic              stop_sec_q;
  logic              accept;
  logic              restart;
  logic              bit_end;
  par_type_e         par_sel;
`ifdef UART_TX_BREAK_EN
  logic              brk_hold_q;
`endif

  assign par_sel = par_type_e'(par_type);
  assign accept  = tx_valid && tx_ready;

  // The timer is held cleared while idle so every frame starts on a full bit period.
`ifdef UART_TX_BREAK_EN
  assign restart = (state == IDLE) || ((state == BREAK) && !brk_hold_q);
`else
  assign restart = (state == IDLE);
`endif

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_tick(baud_tick),
    .restart  (restart),
    .bit_end  (bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_out     <= 1'b1;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      stop_sec_q <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_hold_q <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (send_break) begin
            state      <= BREAK;
            tx_out     <= 1'b0;
            tx_ready   <= 1'b0;
            tx_busy    <= 1'b1;
            brk_hold_q <= 1'b0;
          end else
`endif
          if (accept) begin
            state      <= START;
            tx_out     <= 1'b0;
            tx_ready   <= 1'b0;
            tx_busy    <= 1'b1;
            shreg      <= data_in;
            bit_cnt    <= '0;
            par_bit_q  <= calc_parity(MAX_DWIDTH'(data_in), par_sel);
            par_en_q   <= (par_sel == PAR_ODD) || (par_sel == PAR_EVEN);
            stop2_q    <= stop2;
            stop_sec_q <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state  <= DATA;
            tx_out <= shreg[0];
            shreg  <= shreg >> 1;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (par_en_q) begin
                state  <= PARITY;
                tx_out <= par_bit_q;
              end else begin
                state  <= STOP;
                tx_out <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_out  <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state  <= STOP;
            tx_out <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (stop2_q && !stop_sec_q) begin
              stop_sec_q <= 1'b1;
            end else begin
              state    <= IDLE;
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
            end
          end
        end
`ifdef UART_TX_BREAK_EN
        BREAK: begin
          if (!brk_hold_q) begin
            if (!send_break) begin
              tx_out     <= 1'b1;
              brk_hold_q <= 1'b1;
            end
          end else if (bit_end) begin
            state    <= IDLE;
            tx_ready <= 1'b1;
            tx_busy  <= 1'b0;
          end
        end
`endif
        default: begin
          state    <= IDLE;
          tx_out   <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame with DWIDTH=8, OVERSAMPLE=16.
module tb_uart_tx_frame;

  localparam int DWIDTH     = 8;
  localparam int OVERSAMPLE = 16;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b0;
  logic              baud_tick = 1'b1;
  logic              tx_valid  = 1'b0;
  logic [DWIDTH-1:0] data_in   = '0;
  logic [1:0]        par_type  = 2'b00;
  logic              stop2     = 1'b0;
  logic              tx_ready;
  logic              tx_out;
  logic              tx_busy;
  logic              tx_done;

  int checks   = 0;
  int errors   = 0;
  int tick_div = 1;
  int phase    = 0;

  uart_tx_frame #(
    .DWIDTH    (DWIDTH),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_tick(baud_tick),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .data_in  (data_in),
    .par_type (par_type),
    .stop2    (stop2),
    .tx_out   (tx_out),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  // Advance one clock; baud_tick for the following edge fires every tick_div cycles.
  task automatic cyc();
    @(posedge clk);
    #1;
    phase++;
    baud_tick = (((phase + 1) % tick_div) == 0);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic accept_frame(input logic [7:0] d, input logic [1:0] pt, input logic s2);
    int budget;
    budget   = 0;
    data_in  = d;
    par_type = pt;
    stop2    = s2;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && budget < 1000) begin
      cyc();
      budget++;
    end
    chk("ready_before_accept", tx_ready, 1'b1);
    cyc();
    phase     = 0;
    baud_tick = (tick_div == 1);
    chk("busy_after_accept", tx_busy, 1'b1);
    chk("ready_after_accept", tx_ready, 1'b0);
  endtask

  // Entered in the first cycle of the start bit; leaves in the tx_done cycle.
  task automatic check_bits(input string tag, input logic [15:0] bits,
                            input int nbits, input int blen);
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < blen; c++) begin
        chk($sformatf("%s_bit%0d_cyc%0d", tag, k, c), tx_out, bits[k]);
        chk($sformatf("%s_nodone%0d_cyc%0d", tag, k, c), tx_done, 1'b0);
        cyc();
      end
    end
    chk({tag, "_done"}, tx_done, 1'b1);
    chk({tag, "_ready_end"}, tx_ready, 1'b1);
    chk({tag, "_busy_end"}, tx_busy, 1'b0);
    chk({tag, "_line_end"}, tx_out, 1'b1);
  endtask

  initial begin
    // Reset state
    repeat (3) cyc();
    chk("rst_tx_out", tx_out, 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    rst_n = 1'b1;
    repeat (2) cyc();
    chk("idle_line", tx_out, 1'b1);

    // 0x55 even parity, one stop: 0,10101010,par 0,1
    accept_frame(8'h55, 2'b10, 1'b0);
    tx_valid = 1'b0;
    check_bits("f55_even", 16'h04AA, 11, 16);
    cyc();
    chk("f55_done_one_cycle", tx_done, 1'b0);

    // 0xA7 odd: five ones -> parity 0
    accept_frame(8'hA7, 2'b01, 1'b0);
    tx_valid = 1'b0;
    check_bits("fA7_odd", 16'h054E, 11, 16);
    cyc();

    // 0xA6 odd: four ones -> parity 1
    accept_frame(8'hA6, 2'b01, 1'b0);
    tx_valid = 1'b0;
    check_bits("fA6_odd", 16'h074C, 11, 16);
    cyc();

    // 0xFF no parity (00 and 11), two stop bits
    accept_frame(8'hFF, 2'b00, 1'b1);
    tx_valid = 1'b0;
    check_bits("fFF_none00", 16'h07FE, 11, 16);
    cyc();
    accept_frame(8'hFF, 2'b11, 1'b1);
    tx_valid = 1'b0;
    check_bits("fFF_none11", 16'h07FE, 11, 16);
    cyc();

    // Back-to-back: inputs change right after acceptance; second frame taken in done cycle
    accept_frame(8'h55, 2'b10, 1'b0);
    data_in  = 8'h0F;
    par_type = 2'b00;
    check_bits("b2b_first", 16'h04AA, 11, 16);
    cyc();
    phase     = 0;
    baud_tick = 1'b1;
    chk("b2b_start_low", tx_out, 1'b0);
    chk("b2b_busy", tx_busy, 1'b1);
    chk("b2b_done_cleared", tx_done, 1'b0);
    tx_valid = 1'b0;
    check_bits("b2b_second", 16'h021E, 10, 16);
    cyc();
    chk("b2b_idle_after", tx_ready, 1'b1);

    // baud_tick every 4th cycle: 64 clocks per bit
    tick_div = 4;
    accept_frame(8'h3C, 2'b10, 1'b0);
    tx_valid = 1'b0;
    check_bits("f3C_div4", 16'h0478, 11, 64);
    cyc();
    tick_div  = 1;
    baud_tick = 1'b1;

    // Asynchronous reset in the middle of the data bits
    accept_frame(8'h00, 2'b00, 1'b0);
    tx_valid = 1'b0;
    repeat (56) cyc();
    chk("mid_data_low", tx_out, 1'b0);
    chk("mid_data_busy", tx_busy, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx_out", tx_out, 1'b1);
    chk("async_rst_ready", tx_ready, 1'b1);
    chk("async_rst_busy", tx_busy, 1'b0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cyc();
      chk($sformatf("post_rst_line_%0d", i), tx_out, 1'b1);
      chk($sformatf("post_rst_busy_%0d", i), tx_busy, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
